// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: the PLL-side and status signals of the PLL supervisor.
// The master drives the lock status and the restart request. The slave (the
// supervisor) returns the PLL reset, the ready flag, the state code, the
// lock-loss counter and the fault flag.
interface pll_supervisor_if;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;
    logic       fault;

    modport master (
        output pll_locked, restart,
        input  pll_rst, ready, state, lock_loss_cnt, fault
    );

    modport slave (
        input  pll_locked, restart,
        output pll_rst, ready, state, lock_loss_cnt, fault
    );
endinterface

// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences the PLL reset, waits for lock with a timeout,
// qualifies lock as stable, and only then declares the clocks usable. It
// restarts the PLL on lock loss or timeout, and it counts lock losses.
// The block runs in the reference-clock domain.
// Optional feature: define PLL_SUPERVISOR_RETRY_LIMIT_EN to add a retry
// counter and an absorbing FAULT state. Without it, timeouts retry forever
// and the fault output is tied to 0.
module pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input logic        clk,
    input logic        rst_n,
    pll_supervisor_if.slave sup
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam logic [19:0] RST_LAST    = 20'(RST_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STABLE_LAST = 20'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || RST_CYCLES > 1048576 ||
        LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 1048575 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 1048575 ||
        MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_param_check
        $error("pll_supervisor: parameter out of range");
    end

    logic        sync1_q;
    logic        locked_s_q;
    state_e      state_q, state_d;
    logic [19:0] timer_q, timer_d;
    logic [7:0]  llc_q, llc_d;
    logic        pll_rst_q;
    logic        ready_q;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);
    logic [3:0]  retry_q, retry_d;
    logic        fault_q;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= sup.pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    // Next-state, lock-loss counter and retry counter; restart overrides everything
    always_comb begin
        state_d = state_q;
        llc_d   = llc_q;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
        retry_d = retry_q;
`endif
        if (sup.restart) begin
            state_d = ST_RESET;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
            retry_d = 4'd0;
`endif
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (timer_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
                        retry_d = retry_q + 4'd1;
                        state_d = (retry_d >= MAX_R) ? ST_FAULT : ST_RESET;
`else
                        state_d = ST_RESET;
`endif
                    end
                end
                ST_STABLE: begin
                    // A lock drop here is a glitch. It is not counted as a
                    // loss; the FSM just goes back to waiting for lock.
                    if (!locked_s_q) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
                        retry_d = 4'd0;
`endif
                    end
                end
                ST_RUN: begin
                    if (!locked_s_q) begin
                        state_d = ST_RESET;
                        if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
                    end
                end
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
                ST_FAULT: state_d = ST_FAULT;
`endif
                default: state_d = ST_RESET;
            endcase
        end
        // The shared timer restarts on every state change and on restart
        timer_d = (sup.restart || (state_d != state_q)) ? 20'd0 : timer_q + 20'd1;
    end

    // FSM state, timer, counters and registered output decode of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            timer_q   <= 20'd0;
            llc_q     <= 8'd0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
            retry_q   <= 4'd0;
            fault_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            llc_q     <= llc_d;
            pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAULT);
            ready_q   <= (state_d == ST_RUN);
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
            retry_q   <= retry_d;
            fault_q   <= (state_d == ST_FAULT);
`endif
        end
    end

    assign sup.state         = state_q;
    assign sup.pll_rst       = pll_rst_q;
    assign sup.ready         = ready_q;
    assign sup.lock_loss_cnt = llc_q;
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
    assign sup.fault         = fault_q;
`else
    assign sup.fault         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed bench for pll_supervisor with RST_CYCLES=4,
// LOCK_TIMEOUT=20, STABLE_CYCLES=8 and MAX_RETRY=2. A vector table walks
// the power-up, lock-loss, timeout and STABLE-glitch sequence edge by edge.
// Hand-written sequences then cover restart, counter saturation,
// asynchronous reset and the timeout/fault behaviour.
module tb_pll_supervisor;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pll_supervisor_if sif();

    pll_supervisor #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRY(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sup   (sif.slave)
    );

    typedef struct {
        logic       locked;
        int         n;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic [7:0] llc;
    } vec_t;

    vec_t tbl [20];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // locked, edges, state, pll_rst, ready, lock_loss_cnt (edge count in comment)
        tbl[0]  = '{1'b1, 3,  3'd0, 1'b1, 1'b0, 8'd0}; // e3  RESET timer 3
        tbl[1]  = '{1'b1, 1,  3'd1, 1'b0, 1'b0, 8'd0}; // e4  WAIT_LOCK
        tbl[2]  = '{1'b1, 1,  3'd2, 1'b0, 1'b0, 8'd0}; // e5  STABLE
        tbl[3]  = '{1'b1, 7,  3'd2, 1'b0, 1'b0, 8'd0}; // e12 STABLE timer 7
        tbl[4]  = '{1'b1, 1,  3'd3, 1'b0, 1'b1, 8'd0}; // e13 RUN
        tbl[5]  = '{1'b0, 2,  3'd3, 1'b0, 1'b1, 8'd0}; // sync latency
        tbl[6]  = '{1'b0, 1,  3'd0, 1'b1, 1'b0, 8'd1}; // 3rd edge: lock loss
        tbl[7]  = '{1'b0, 3,  3'd0, 1'b1, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1,  3'd1, 1'b0, 1'b0, 8'd1}; // WAIT_LOCK, no lock
        tbl[9]  = '{1'b0, 19, 3'd1, 1'b0, 1'b0, 8'd1}; // timer 19
        tbl[10] = '{1'b0, 1,  3'd0, 1'b1, 1'b0, 8'd1}; // timeout -> RESET
        tbl[11] = '{1'b1, 4,  3'd1, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 1,  3'd2, 1'b0, 1'b0, 8'd1}; // STABLE timer 0
        tbl[13] = '{1'b1, 3,  3'd2, 1'b0, 1'b0, 8'd1}; // timer 3
        tbl[14] = '{1'b0, 1,  3'd2, 1'b0, 1'b0, 8'd1}; // 1-cycle glitch
        tbl[15] = '{1'b1, 1,  3'd2, 1'b0, 1'b0, 8'd1}; // timer 5, locked_s low
        tbl[16] = '{1'b1, 1,  3'd1, 1'b0, 1'b0, 8'd1}; // back to WAIT_LOCK
        tbl[17] = '{1'b1, 1,  3'd2, 1'b0, 1'b0, 8'd1}; // STABLE from 0
        tbl[18] = '{1'b1, 7,  3'd2, 1'b0, 1'b0, 8'd1};
        tbl[19] = '{1'b1, 1,  3'd3, 1'b0, 1'b1, 8'd1}; // RUN, glitch uncounted

        rst_n          = 1'b0;
        sif.pll_locked = 1'b1;
        sif.restart    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   sif.state, 0);
        chk("rst_pll_rst", sif.pll_rst, 1);
        chk("rst_ready",   sif.ready, 0);
        chk("rst_llc",     sif.lock_loss_cnt, 0);
        chk("rst_fault",   sif.fault, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            sif.pll_locked = tbl[i].locked;
            step(tbl[i].n);
            chk($sformatf("vec%0d_state", i),   sif.state, tbl[i].st);
            chk($sformatf("vec%0d_pll_rst", i), sif.pll_rst, tbl[i].prst);
            chk($sformatf("vec%0d_ready", i),   sif.ready, tbl[i].rdy);
            chk($sformatf("vec%0d_llc", i),     sif.lock_loss_cnt, tbl[i].llc);
            chk($sformatf("vec%0d_fault", i),   sif.fault, 0);
        end

        // restart in the same cycle that locked_s falls in RUN: no count
        sif.pll_locked = 1'b0;
        step(2);
        chk("rsim_pre_state", sif.state, 3);
        sif.restart = 1'b1;
        step(1);
        sif.restart = 1'b0;
        chk("rsim_state", sif.state, 0);
        chk("rsim_ready", sif.ready, 0);
        chk("rsim_llc",   sif.lock_loss_cnt, 1);

        // restart held keeps RESET; release gives a fresh 13-edge attempt
        sif.pll_locked = 1'b1;
        sif.restart    = 1'b1;
        step(10);
        chk("rhold_state",   sif.state, 0);
        chk("rhold_pll_rst", sif.pll_rst, 1);
        sif.restart = 1'b0;
        step(12);
        chk("rrel_state12", sif.state, 2);
        chk("rrel_ready12", sif.ready, 0);
        step(1);
        chk("rrel_state13", sif.state, 3);
        chk("rrel_ready13", sif.ready, 1);

        // 300 lock losses saturate the counter at 255
        for (int i = 0; i < 300; i++) begin
            int k;
            sif.pll_locked = 1'b0;
            step(3);
            if (i == 0) begin
                chk("loss_ready", sif.ready, 0);
                chk("loss_prst",  sif.pll_rst, 1);
                chk("loss_llc",   sif.lock_loss_cnt, 2);
            end
            sif.pll_locked = 1'b1;
            k = 0;
            while (sif.ready !== 1'b1 && k < 30) begin
                step(1);
                k++;
            end
            if (sif.ready !== 1'b1) begin
                chk("relock_timeout", sif.ready, 1);
                break;
            end
        end
        chk("sat_llc", sif.lock_loss_cnt, 255);

        // async reset mid-STABLE takes effect before the next edge
        sif.restart = 1'b1;
        step(1);
        sif.restart = 1'b0;
        step(8);
        chk("mid_state", sif.state, 2);
        #2;
        rst_n          = 1'b0;
        sif.pll_locked = 1'b0;
        #1;
        chk("arst_state",   sif.state, 0);
        chk("arst_pll_rst", sif.pll_rst, 1);
        chk("arst_ready",   sif.ready, 0);
        chk("arst_llc",     sif.lock_loss_cnt, 0);
        chk("arst_fault",   sif.fault, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // no lock: pll_rst is high 4 edges and low 20, repeating
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
        for (int k = 1; k <= 47; k++) begin
`else
        for (int k = 1; k <= 72; k++) begin
`endif
            step(1);
            chk($sformatf("to_prst_e%0d", k), sif.pll_rst, ((k % 24) < 4) ? 1 : 0);
            chk($sformatf("to_ready_e%0d", k), sif.ready, 0);
        end
`ifdef PLL_SUPERVISOR_RETRY_LIMIT_EN
        step(1);
        chk("flt_state", sif.state, 4);
        chk("flt_fault", sif.fault, 1);
        chk("flt_prst",  sif.pll_rst, 1);
        step(5);
        chk("flt_hold_state", sif.state, 4);
        chk("flt_hold_prst",  sif.pll_rst, 1);
        sif.restart = 1'b1;
        step(1);
        sif.restart = 1'b0;
        chk("flt_rs_state", sif.state, 0);
        chk("flt_rs_fault", sif.fault, 0);
`else
        chk("to_fault", sif.fault, 0);
        chk("to_state", sif.state, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
# pll_supervisor

Sequencing controller for the clock-generation PLL. It drives the PLL reset, waits for lock with a timeout, and qualifies lock as stable before declaring clocks usable. It restarts the PLL on lock loss or timeout and counts lock-loss events. It runs in the reference-clock domain (50 MHz) beside the PLL, and its `ready` output gates the system resets of the audio/derived clock domains.

## Interface
Parameters:
- `RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK before retry, 1 ms at 50 MHz (≥1, ≤2^20-1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1, ≤2^20-1).
- `MAX_RETRY`, 3: failed attempts before FAULT; used only with the config macro (1..15).

Ports:
- `clk` in 1: reference clock, same net as PLL refclk.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL locked, asynchronous; 2-flop synchronized internally to `locked_s`.
- `restart` in 1: single-cycle request for a full relock sequence.
- `pll_rst` out 1: PLL reset, active-high.
- `ready` out 1: clocks valid.
- `state` out 3: current FSM state code.
- `lock_loss_cnt` out 8: saturating count of lock losses in RUN.
- `fault` out 1: retry limit exhausted (macro only; else constant 0).

## Operation
- One 20-bit timer, cleared on every state change. Outputs decode the state register only, so they are glitch-free.
- States: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- Output decode: `pll_rst` = (RESET or FAULT); `ready` = RUN; `fault` = FAULT.
- RESET: when timer == RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK has two exits, checked in this order:
  - `locked_s` high: go to STABLE.
  - Timer == LOCK_TIMEOUT-1: retry_cnt++ and go to RESET. With the macro, go to FAULT instead once retry_cnt reaches MAX_RETRY.
- STABLE has two exits, checked in this order:
  - `locked_s` low: back to WAIT_LOCK. This is a glitch; it is not counted and the retry timer restarts.
  - Timer == STABLE_CYCLES-1: go to RUN and clear retry_cnt.
- RUN: `locked_s` low sends the FSM to RESET and increments `lock_loss_cnt`, which saturates at 255.
- FAULT (macro only): absorbing. Exits only via `restart` or `rst_n`.
- `restart` high in any state:
  - Goes to RESET, clearing timer and retry_cnt.
  - Has priority over all other transitions in the same cycle.
  - A simultaneous lock loss in RUN is not counted.
  - `restart` held high keeps the FSM in RESET.
- Async reset (`rst_n` low) gives:
  - state=RESET, timer=0, retry_cnt=0, sync flops=0.
  - `pll_rst`=1, `ready`=0, `lock_loss_cnt`=0, `fault`=0.
  - These take effect immediately, from any state, mid-sequence included.

## Timing
- Counting starts at the first rising edge with `rst_n` high. Reset release has no synchronizer requirement beyond the team reset bridge.
- Synchronizer latency: `pll_locked` change to `locked_s` is 2 edges. The FSM reacts on the 3rd edge.
- Fresh attempt with lock already present: ready rises RST_CYCLES + 1 + STABLE_CYCLES edges after entering RESET.
- Lock loss in RUN: `ready` falls and `pll_rst` rises 3 edges after `pll_locked` falls.
- Timeout period (no lock): `pll_rst` high RST_CYCLES cycles, low LOCK_TIMEOUT cycles, repeating.
- `restart` takes effect on the next edge: `ready` falls 1 edge after the `restart` cycle.

## Configuration
- `PLL_SUPERVISOR_RETRY_LIMIT_EN` defined:
  - retry_cnt (4 bits) is compared against MAX_RETRY.
  - Reaching it enters FAULT, which holds `pll_rst`=1 and `fault`=1.
- Undefined:
  - No retry_cnt, no FAULT state.
  - Timeouts retry indefinitely; `fault` tied to 0.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
- Release `rst_n` with `pll_locked`=1 -> `pll_rst` high for 4 edges; `ready` rises exactly 13 edges after the first edge; `lock_loss_cnt`=0.
- `pll_locked`=0 permanently, macro off -> `pll_rst` pulses 4 high / 20 low forever; `ready`=0, `fault`=0.
- Same stimulus with macro on -> after 2 timeouts, `state`=4, `fault`=1, `pll_rst`=1 held. A `restart` pulse then gives `state`=0, `fault`=0 on the next edge.
- 1-cycle low glitch on `pll_locked` while in STABLE (timer=5) -> FSM returns to WAIT_LOCK, then STABLE restarts from 0; `ready` never pulses; `lock_loss_cnt` stays 0.
- Drop `pll_locked` in RUN -> `ready` falls 3 edges later, `lock_loss_cnt`=1. Repeat for 300 losses -> `lock_loss_cnt`=255.
- Two cases:
  - `restart` in the same cycle that `locked_s` falls in RUN -> RESET, `lock_loss_cnt` unchanged.
  - `rst_n` asserted mid-STABLE -> all outputs at reset values before the next edge.
